// File: rtl/pavana_resp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pavana_resp_sequencer
// Description : Per-master in-order read-response sequencer. Tags record the
//               target slave of each read; responses are released in order.
// Revision    : 1.0 - initial release
// ============================================================================
module pavana_resp_sequencer #(
    parameter int NUM_SLAVES  = 4,
    parameter int SNUM_WIDTH  = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_ORDER = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             tag_wrreq_i,
    input  logic [SNUM_WIDTH-1:0]            tag_wdata_i,
    output logic                             tag_full_o,
    input  logic [NUM_SLAVES-1:0]            resp_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] resp_data_i,
    output logic                             resp_o,
    output logic [DATA_WIDTH-1:0]            resp_data_o,
    output logic [DEPTH_ORDER:0]             outstanding_o,
    output logic [1:0]                       err_o,
    input  logic                             err_clr_i
);

    localparam int                    c_DEPTH   = 2 ** DEPTH_ORDER;
    localparam logic [DEPTH_ORDER:0]  c_FULL    = (DEPTH_ORDER+1)'(c_DEPTH);
    localparam logic [SNUM_WIDTH:0]   c_NUM_SLV = (SNUM_WIDTH+1)'(NUM_SLAVES);

    // Tag FIFO state
    logic [SNUM_WIDTH-1:0]  r_tag_mem [c_DEPTH];
    logic [DEPTH_ORDER-1:0] r_tag_wptr;
    logic [DEPTH_ORDER-1:0] r_tag_rptr;
    logic [DEPTH_ORDER:0]   r_tag_cnt;
    logic                   r_tag_full;

    // Output registers
    logic                   r_resp;
    logic [DATA_WIDTH-1:0]  r_resp_data;
    logic [1:0]             r_err;

    logic                             w_push;
    logic                             w_rel;
    logic [SNUM_WIDTH-1:0]            w_head;
    logic                             w_head_rdy;
    logic [DATA_WIDTH-1:0]            w_head_data;
    logic [DEPTH_ORDER:0]             w_cnt_next;
    logic [NUM_SLAVES-1:0]            w_snz;
    logic [NUM_SLAVES-1:0]            w_drop;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] w_sdata;
    logic [1:0]                       w_err_new;

    // Out-of-range slave indices are refused exactly like a push while full
    assign w_push     = tag_wrreq_i & ~r_tag_full & ({1'b0, tag_wdata_i} < c_NUM_SLV);
    assign w_head     = r_tag_mem[r_tag_rptr];
    assign w_rel      = (r_tag_cnt != '0) & w_head_rdy;
    assign w_cnt_next = r_tag_cnt + (DEPTH_ORDER+1)'(w_push) - (DEPTH_ORDER+1)'(w_rel);
    assign w_err_new  = {tag_wrreq_i & ~w_push, |w_drop};

    always_comb begin
        w_head_rdy  = 1'b0;
        w_head_data = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (w_head == SNUM_WIDTH'(k)) begin
                w_head_rdy  = w_snz[k];
                w_head_data = w_sdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_tag_mem[r_tag_wptr] <= tag_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
            r_tag_cnt  <= '0;
            r_tag_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag_wptr <= r_tag_wptr + 1'b1;
            end
            if (w_rel) begin
                r_tag_rptr <= r_tag_rptr + 1'b1;
            end
            r_tag_cnt  <= w_cnt_next;
            r_tag_full <= (w_cnt_next == c_FULL);
        end
    end

    // Per-slave response FIFOs; pend counts reads issued but not yet released
    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_slave
        logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];
        logic [DEPTH_ORDER-1:0] r_wptr;
        logic [DEPTH_ORDER-1:0] r_rptr;
        logic [DEPTH_ORDER:0]   r_pend;
        logic [DEPTH_ORDER:0]   r_scnt;
        logic                   w_cap;
        logic                   w_inc;
        logic                   w_dec;

        assign w_cap = resp_i[k] & (r_pend > r_scnt);
        assign w_inc = w_push & (tag_wdata_i == SNUM_WIDTH'(k));
        assign w_dec = w_rel & (w_head == SNUM_WIDTH'(k));

        assign w_snz[k]                                = (r_scnt != '0);
        assign w_drop[k]                               = resp_i[k] & ~w_cap;
        assign w_sdata[k*DATA_WIDTH +: DATA_WIDTH]     = r_mem[r_rptr];

        always_ff @(posedge clk_i) begin
            if (w_cap) begin
                r_mem[r_wptr] <= resp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_pend <= '0;
                r_scnt <= '0;
            end else begin
                if (w_cap) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_dec) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_pend <= r_pend + (DEPTH_ORDER+1)'(w_inc) - (DEPTH_ORDER+1)'(w_dec);
                r_scnt <= r_scnt + (DEPTH_ORDER+1)'(w_cap) - (DEPTH_ORDER+1)'(w_dec);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp      <= 1'b0;
            r_resp_data <= '0;
            r_err       <= '0;
        end else begin
            r_resp <= w_rel;
            if (w_rel) begin
                r_resp_data <= w_head_data;
            end
            // A fresh error in the clear cycle survives the clear
            r_err <= (err_clr_i ? 2'b00 : r_err) | w_err_new;
        end
    end

    assign tag_full_o    = r_tag_full;
    assign outstanding_o = r_tag_cnt;
    assign resp_o        = r_resp;
    assign resp_data_o   = r_resp_data;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pavana_resp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pavana_resp_sequencer
// Description : Directed self-checking bench for pavana_resp_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pavana_resp_sequencer;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         tag_wrreq_i;
    logic [1:0]   tag_wdata_i;
    logic         tag_full_o;
    logic [3:0]   resp_i;
    logic [127:0] resp_data_i;
    logic         resp_o;
    logic [31:0]  resp_data_o;
    logic [3:0]   outstanding_o;
    logic [1:0]   err_o;
    logic         err_clr_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    pavana_resp_sequencer #(
        .NUM_SLAVES (4),
        .SNUM_WIDTH (2),
        .DATA_WIDTH (32),
        .DEPTH_ORDER(3)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .tag_wrreq_i  (tag_wrreq_i),
        .tag_wdata_i  (tag_wdata_i),
        .tag_full_o   (tag_full_o),
        .resp_i       (resp_i),
        .resp_data_i  (resp_data_i),
        .resp_o       (resp_o),
        .resp_data_o  (resp_data_o),
        .outstanding_o(outstanding_o),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i)
    );

    typedef struct {
        logic         rst;
        logic         wrreq;
        logic [1:0]   wdata;
        logic [3:0]   resp;
        logic [127:0] rdata;
        logic         clr;
        logic         e_resp;
        logic [31:0]  e_data;
        logic [3:0]   e_out;
        logic         e_full;
        logic [1:0]   e_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic wrreq, input logic [1:0] wdata,
                                input logic [3:0] resp, input logic [127:0] rdata, input logic clr,
                                input logic e_resp, input logic [31:0] e_data, input logic [3:0] e_out,
                                input logic e_full, input logic [1:0] e_err);
        vec_t v;
        v.rst = rst; v.wrreq = wrreq; v.wdata = wdata; v.resp = resp; v.rdata = rdata;
        v.clr = clr; v.e_resp = e_resp; v.e_data = e_data; v.e_out = e_out;
        v.e_full = e_full; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic drive(input logic rst, input logic wrreq, input logic [1:0] wdata,
                         input logic [3:0] resp, input logic [127:0] rdata, input logic clr);
        @(negedge clk_i);
        rst_i = rst; tag_wrreq_i = wrreq; tag_wdata_i = wdata;
        resp_i = resp; resp_data_i = rdata; err_clr_i = clr;
        @(posedge clk_i);
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] d;
    logic        p, r, prev_cap;
    int          issued, sent, rels, mout;

    initial begin
        rst_i = 1'b1; tag_wrreq_i = 1'b0; tag_wdata_i = '0;
        resp_i = '0; resp_data_i = '0; err_clr_i = 1'b0;

        // Out-of-order return across two slaves
        vt.push_back(mk(1, 0, 0, 4'b0000, 128'h0, 0, 0, 32'h0,        4'd0, 0, 2'b00));
        vt.push_back(mk(0, 1, 1, 4'b0000, 128'h0, 0, 0, 32'h0,        4'd1, 0, 2'b00));
        vt.push_back(mk(0, 1, 0, 4'b0000, 128'h0, 0, 0, 32'h0,        4'd2, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0001, 128'hAAAA0000, 0, 0, 32'h0, 4'd2, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 0, 0, 32'h0,        4'd2, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0010, 128'h11111111_00000000, 0, 0, 32'h0, 4'd2, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 0, 1, 32'h11111111, 4'd1, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 0, 1, 32'hAAAA0000, 4'd0, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 0, 0, 32'hAAAA0000, 4'd0, 0, 2'b00));
        // Unexpected response, clear, and error-wins-over-clear
        vt.push_back(mk(0, 0, 0, 4'b0010, 128'h12345678_00000000, 0, 0, 32'hAAAA0000, 4'd0, 0, 2'b01));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 1, 0, 32'hAAAA0000, 4'd0, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0100, 128'h0, 1, 0, 32'hAAAA0000, 4'd0, 0, 2'b01));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 1, 0, 32'hAAAA0000, 4'd0, 0, 2'b00));
        // All four slaves respond together to tags 3,2,1,0
        vt.push_back(mk(0, 1, 3, 4'b0000, 128'h0, 0, 0, 32'hAAAA0000, 4'd1, 0, 2'b00));
        vt.push_back(mk(0, 1, 2, 4'b0000, 128'h0, 0, 0, 32'hAAAA0000, 4'd2, 0, 2'b00));
        vt.push_back(mk(0, 1, 1, 4'b0000, 128'h0, 0, 0, 32'hAAAA0000, 4'd3, 0, 2'b00));
        vt.push_back(mk(0, 1, 0, 4'b0000, 128'h0, 0, 0, 32'hAAAA0000, 4'd4, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b1111, {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000},
                        0, 0, 32'hAAAA0000, 4'd4, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 0, 1, 32'hD0000003, 4'd3, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 0, 1, 32'hD0000002, 4'd2, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 0, 1, 32'hD0000001, 4'd1, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 0, 1, 32'hD0000000, 4'd0, 0, 2'b00));
        vt.push_back(mk(0, 0, 0, 4'b0000, 128'h0, 0, 0, 32'hD0000000, 4'd0, 0, 2'b00));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].wrreq, vt[i].wdata, vt[i].resp, vt[i].rdata, vt[i].clr);
            chk($sformatf("vec%0d.resp", i), 64'(resp_o),        64'(vt[i].e_resp));
            chk($sformatf("vec%0d.data", i), 64'(resp_data_o),   64'(vt[i].e_data));
            chk($sformatf("vec%0d.out",  i), 64'(outstanding_o), 64'(vt[i].e_out));
            chk($sformatf("vec%0d.full", i), 64'(tag_full_o),    64'(vt[i].e_full));
            chk($sformatf("vec%0d.err",  i), 64'(err_o),         64'(vt[i].e_err));
        end

        // Fill the tag FIFO, overflow it, then release one entry
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 2, 4'b0000, 128'h0, 0);
            chk($sformatf("fill%0d.full", i), 64'(tag_full_o), 64'(i == 7));
            chk($sformatf("fill%0d.out", i), 64'(outstanding_o), 64'(i + 1));
        end
        drive(0, 1, 2, 4'b0000, 128'h0, 0);
        chk("ovf.err",  64'(err_o),         64'(2'b10));
        chk("ovf.out",  64'(outstanding_o), 64'd8);
        chk("ovf.full", 64'(tag_full_o),    64'd1);
        drive(0, 0, 0, 4'b0100, 128'h22220001_00000000_00000000, 0);
        chk("ovf.cap_resp", 64'(resp_o), 64'd0);
        drive(0, 0, 0, 4'b0000, 128'h0, 0);
        chk("ovf.rel_resp", 64'(resp_o),        64'd1);
        chk("ovf.rel_data", 64'(resp_data_o),   64'h22220001);
        chk("ovf.rel_out",  64'(outstanding_o), 64'd7);
        chk("ovf.rel_full", 64'(tag_full_o),    64'd0);

        // Reset mid-operation discards tags and buffered responses
        drive(1, 0, 0, 4'b0000, 128'h0, 0);
        chk("rst1.err", 64'(err_o), 64'd0);
        chk("rst1.data", 64'(resp_data_o), 64'd0);
        drive(0, 1, 1, 4'b0000, 128'h0, 0);
        drive(0, 1, 2, 4'b0000, 128'h0, 0);
        drive(0, 1, 0, 4'b0000, 128'h0, 0);
        drive(0, 0, 0, 4'b0001, 128'h00000005, 0);
        chk("pre_rst.out",  64'(outstanding_o), 64'd3);
        chk("pre_rst.resp", 64'(resp_o),        64'd0);
        drive(1, 0, 0, 4'b0000, 128'h0, 0);
        chk("rst2.out",  64'(outstanding_o), 64'd0);
        chk("rst2.full", 64'(tag_full_o),    64'd0);
        chk("rst2.resp", 64'(resp_o),        64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 4'b0000, 128'h0, 0);
            chk($sformatf("post_rst%0d.resp", i), 64'(resp_o), 64'd0);
        end
        drive(0, 0, 0, 4'b0010, 128'h00000009_00000000, 0);
        chk("post_rst.err", 64'(err_o), 64'(2'b01));
        drive(0, 0, 0, 4'b0000, 128'h0, 1);
        chk("post_rst.clr", 64'(err_o), 64'd0);

        // Many reads to slave 3 with interleaved push/release; pointers wrap
        issued = 0; sent = 0; rels = 0; mout = 0; prev_cap = 1'b0;
        for (int cyc = 0; cyc < 300 && rels < 20; cyc++) begin
            p = (cyc % 5 != 4) && (issued < 20) && (mout < 8);
            r = (cyc % 3 != 0) && (sent < issued);
            d = 32'hC0000000 + 32'(sent);
            drive(0, p, 2'd3, r ? 4'b1000 : 4'b0000, r ? {d, 96'h0} : 128'h0, 0);
            mout = mout + int'(p) - int'(prev_cap);
            if (p) issued++;
            chk($sformatf("wrap%0d.resp", cyc), 64'(resp_o), 64'(prev_cap));
            if (prev_cap) begin
                chk($sformatf("wrap%0d.data", cyc), 64'(resp_data_o), 64'(q.pop_front()));
                rels++;
            end
            if (r) begin
                q.push_back(d);
                sent++;
            end
            chk($sformatf("wrap%0d.out", cyc),  64'(outstanding_o), 64'(mout));
            chk($sformatf("wrap%0d.full", cyc), 64'(tag_full_o),    64'(mout == 8));
            prev_cap = r;
        end
        chk("wrap.count", 64'(rels), 64'd20);
        chk("wrap.err",   64'(err_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pavana_resp_sequencer.md
Name: pavana_resp_sequencer

Overview:
- Per-master in-order read-response sequencer for the pavana crossbar family, parametrised in slave count, data width and buffer depth.
- On every accepted read it records the target slave index in an order (tag) FIFO.
- Read responses arriving from any slave land in per-slave response FIFOs and are released to the master strictly in request-issue order, through a registered output.
- Adds outstanding-count reporting and sticky protocol-error detection.

Parameters:
- NUM_SLAVES, 4, number of slave response inputs (2..16).
- SNUM_WIDTH, 2, slave-index width; must satisfy 2^SNUM_WIDTH >= NUM_SLAVES.
- DATA_WIDTH, 32, response data width.
- DEPTH_ORDER, 3, log2 of tag-FIFO depth and of each per-slave FIFO depth (depth D = 2^DEPTH_ORDER).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- tag_wrreq_i  in  1  read request accepted by a slave-side arbiter this cycle.
- tag_wdata_i  in  SNUM_WIDTH  target slave index of that read.
- tag_full_o  out  1  tag FIFO holds D entries; the master read request must be gated with this.
- resp_i  in  NUM_SLAVES  per-slave response strobe already routed to this master.
- resp_data_i  in  NUM_SLAVES*DATA_WIDTH  per-slave response data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- resp_o  out  1  in-order response valid, one-cycle pulse per response.
- resp_data_o  out  DATA_WIDTH  in-order response data.
- outstanding_o  out  DEPTH_ORDER+1  number of reads issued whose response has not yet been emitted.
- err_o  out  2  sticky errors: bit0 = unexpected response, bit1 = push while full.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset: tag FIFO and all slave FIFOs empty; pointers, pending counters and outstanding_o = 0; resp_o = 0; resp_data_o = 0; err_o = 0; tag_full_o = 0.
- Reset mid-operation discards every buffered tag and response. No response is emitted after rst_i is sampled high.
- Tag push:
  - Occurs when tag_wrreq_i=1 and tag_full_o=0.
  - Also increments pend[tag_wdata_i], the per-slave count of expected responses.
  - tag_wrreq_i=1 while tag_full_o=1: ignored, err_o[1] set.
  - tag_wdata_i >= NUM_SLAVES: treated as push-while-full (ignored, err_o[1] set).
- Response capture:
  - Each slave k with resp_i[k]=1 and pend[k]>pushed-but-unconsumed count writes resp_data_i slice k into FIFO k in that cycle.
  - Any number of slaves may write in the same cycle.
  - Response with no pending expectation: dropped, err_o[0] set.
  - A per-slave FIFO cannot overflow because outstanding reads are bounded by D.
- Release:
  - Let h be the head tag.
  - When the tag FIFO is non-empty and FIFO h is non-empty (data stored by a previous edge), pop both at the clock edge.
  - At that edge register resp_o=1 and resp_data_o = FIFO h head; otherwise resp_o=0 and resp_data_o holds its last value.
  - At most one release per cycle.
- Latency: response sampled at edge t is written at t; resp_o is high in the cycle after edge t+1. Minimum latency is 2 cycles from resp_i to resp_o.
- Ordering:
  - A younger response from slave B waits while the head tag points to slave A.
  - Multiple reads to the same slave are returned FIFO-ordered.
- Counters and full flag:
  - outstanding_o += push, -= release.
  - Simultaneous push and release leaves outstanding_o unchanged.
  - tag_full_o is registered and equals (tag count == D).
  - A push and a pop in the same cycle while full is impossible because the push is refused. A pop while full deasserts tag_full_o next cycle.
- Pointers wrap modulo D; the count distinguishes full from empty.
- Error flags: err_clr_i clears err_o. If a new error occurs in the same cycle as err_clr_i, the new error wins (bit remains set).

Test Plan:
- Reset then push tags 1,0 (two cycles); slave0 responds 0xAAAA0000 before slave1 responds 0x11111111 -> resp_o emits 0x11111111 then 0xAAAA0000; outstanding_o goes 2->1->0.
- Push 8 tags to slave 2 with D=8 -> tag_full_o=1 the cycle after the 8th push; a 9th push sets err_o=2'b10 and outstanding_o stays 8; one response releases, then tag_full_o=0.
- Slaves 0..3 each respond in the same cycle to tags 3,2,1,0 -> four consecutive resp_o pulses with data in tag order; the first pulse appears 2 cycles after the responses.
- resp_i[1]=1 with no pending read to slave 1 -> data dropped, err_o[0]=1, resp_o stays 0; err_clr_i pulse -> err_o=0.
- 3 tags outstanding and 1 response buffered, then rst_i high for 1 cycle -> outstanding_o=0, resp_o never pulses, tag_full_o=0.
- Over 20 reads to slave 3 with interleaved push and release, the pointers wrap -> data returned in exact issue order and outstanding_o never exceeds 8.
